// File: rtl/pipelined_adder.sv
// WIDTH-bit A+B+Cin adder split into STAGES slices, one slice per stage, carry registered between
// stages, valid/ready on both sides. Define ADDER_SUB_EN to add the Sub input and Overflow output.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef ADDER_SUB_EN
  input  logic             Sub,
  output logic             Overflow,
`endif
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int unsigned SW = (STAGES == 0) ? 1 : WIDTH / STAGES;

  if ((STAGES == 0) || (STAGES > WIDTH) ||
      ((WIDTH % ((STAGES == 0) ? 1 : STAGES)) != 0)) begin : g_param_check
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];

  // Inputs seen by each stage: the primary operands for stage 0, the previous register otherwise.
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;
  logic [STAGES:0]   adv;
  logic [SW:0]       slice;
  logic [WIDTH-1:0]  sum_new;
  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;

`ifdef ADDER_SUB_EN
  logic ovf_q, ovf_d;
  // Subtraction is A + ~B + 1; the forced carry replaces Cin.
  assign b_eff   = Sub ? ~B : B;
  assign cin_eff = Sub ? 1'b1 : Cin;
`else
  assign b_eff   = B;
  assign cin_eff = Cin;
`endif

  always_comb begin
    adv[STAGES] = Out_Ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = ~v_q[k] | adv[k+1];
    end

    src_a[0] = A;
    src_b[0] = b_eff;
    src_s[0] = '0;
    src_c[0] = cin_eff;
    src_v[0] = In_Valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = c_q[k-1];
      src_v[k] = v_q[k-1];
    end

    v_d     = v_q;
    c_d     = c_q;
    s_d     = s_q;
    a_d     = a_q;
    b_d     = b_q;
    slice   = '0;
    sum_new = '0;
    for (int k = 0; k < STAGES; k++) begin
      slice = {1'b0, src_a[k][k*SW +: SW]} + {1'b0, src_b[k][k*SW +: SW]} +
              {{SW{1'b0}}, src_c[k]};
      sum_new = src_s[k];
      sum_new[k*SW +: SW] = slice[SW-1:0];
      if (adv[k]) begin
        v_d[k] = src_v[k];
        c_d[k] = slice[SW];
        s_d[k] = sum_new;
        a_d[k] = src_a[k];
        b_d[k] = src_b[k];
      end
    end

`ifdef ADDER_SUB_EN
    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
    ovf_d = ovf_q;
    if (adv[STAGES-1]) begin
      ovf_d = src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1] ^
              s_d[STAGES-1][WIDTH-1] ^ c_d[STAGES-1];
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      v_q <= '0;
      c_q <= '0;
      s_q <= '{default: '0};
      a_q <= '{default: '0};
      b_q <= '{default: '0};
`ifdef ADDER_SUB_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      v_q <= v_d;
      c_q <= c_d;
      s_q <= s_d;
      a_q <= a_d;
      b_q <= b_d;
`ifdef ADDER_SUB_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign In_Ready  = adv[0];
  assign Out_Valid = v_q[STAGES-1];
  assign Sum       = s_q[STAGES-1];
  assign Cout      = c_q[STAGES-1];
`ifdef ADDER_SUB_EN
  assign Overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4): vector table, random stream,
// backpressure, latency and mid-stream reset, with an in-order expected-result queue.
module tb_pipelined_adder;

  localparam int unsigned W = 16;
  localparam int unsigned S = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         In_Valid;
  logic         In_Ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Out_Valid;
  logic         Out_Ready;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         sub_drv;
`ifdef ADDER_SUB_EN
  logic         Overflow;
`endif

  exp_t sb[$];
  exp_t cur_exp;
  int   n_pass    = 0;
  int   n_total   = 0;
  int   out_count = 0;

  pipelined_adder #(
    .WIDTH (W),
    .STAGES(S)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .In_Valid (In_Valid),
    .In_Ready (In_Ready),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
`ifdef ADDER_SUB_EN
    .Sub      (sub_drv),
    .Overflow (Overflow),
`endif
    .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready),
    .Sum      (Sum),
    .Cout     (Cout)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                 input logic sub);
    logic [W-1:0] bb;
    logic         c;
    logic [W:0]   full;
    exp_t         e;
`ifdef ADDER_SUB_EN
    bb = sub ? ~b : b;
    c  = sub ? 1'b1 : cin;
`else
    bb = b;
    c  = cin;
`endif
    full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return e;
  endfunction

  // Scoreboard: push on accept, pop and compare on output handshake.
  always @(negedge Clk) begin : monitor
    exp_t e;
    if (Reset) begin
      sb.delete();
    end else begin
      if (In_Valid && In_Ready) sb.push_back(cur_exp);
      if (Out_Valid && Out_Ready) begin
        out_count++;
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got sum %0h with nothing outstanding", Sum);
        end else begin
          e = sb.pop_front();
          check("sum", Sum, e.sum);
          check("cout", Cout, e.cout);
`ifdef ADDER_SUB_EN
          check("ovf", Overflow, e.ovf);
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub);
    A        = a;
    B        = b;
    Cin      = cin;
    sub_drv  = sub;
    cur_exp  = model(a, b, cin, sub);
    In_Valid = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 64 && sb.size() != 0; i++) step();
    check(name, sb.size(), 0);
  endtask

  vec_t vecs[10];
  int   n_vec;
  int   acc, cycles, drops, bad, snap;
  logic [W-1:0] bpa[10];
  logic [W-1:0] bpb[10];
  exp_t first;

  initial begin
    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[7] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    n_vec   = 8;
`ifdef ADDER_SUB_EN
    vecs[8] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[9] = '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    n_vec   = 10;
`endif

    Reset     = 1'b1;
    In_Valid  = 1'b0;
    Out_Ready = 1'b1;
    A         = '0;
    B         = '0;
    Cin       = 1'b0;
    sub_drv   = 1'b0;
    cur_exp   = '0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    check("rst_out_valid", Out_Valid, 0);
    check("rst_sum", Sum, 0);
    check("rst_cout", Cout, 0);
    check("rst_in_ready", In_Ready, 1);

    // Single op: valid only after the 3rd edge following the accept edge, for one cycle.
    set_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    step();
    In_Valid = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      check($sformatf("lat_valid_e%0d", e), Out_Valid, (e == 3) ? 1 : 0);
      if (e == 3) begin
        check("single_sum", Sum, 16'h0100);
        check("single_cout", Cout, 0);
      end
    end
    drain("single_drain");

    // Vector table, back-to-back.
    for (int i = 0; i < n_vec; i++) begin
      set_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      cur_exp = '{vecs[i].sum, vecs[i].cout, vecs[i].ovf};
      step();
    end
    In_Valid = 1'b0;
    drain("table_drain");

    // Random stream: one accept per cycle with In_Ready never dropping.
    snap   = out_count;
    acc    = 0;
    cycles = 0;
    drops  = 0;
    while (acc < 100 && cycles < 300) begin
      set_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      @(negedge Clk);
      if (In_Ready) acc++;
      else drops++;
      step();
      cycles++;
    end
    In_Valid = 1'b0;
    check("stream_accepts", acc, 100);
    check("stream_cycles", cycles, 100);
    check("stream_ready_drops", drops, 0);
    drain("stream_drain");
    check("stream_out_count", out_count - snap, 100);

    // Backpressure: output stalled for 10 cycles while feeding.
    for (int i = 0; i < 10; i++) begin
      bpa[i] = W'($urandom);
      bpb[i] = W'($urandom);
    end
    first     = model(bpa[0], bpb[0], 1'b0, 1'b0);
    Out_Ready = 1'b0;
    snap      = out_count;
    acc       = 0;
    bad       = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      set_op(bpa[acc], bpb[acc], 1'b0, 1'b0);
      @(negedge Clk);
      if (In_Ready) acc++;
      if (Out_Valid && (Sum !== first.sum || Cout !== first.cout)) bad++;
      step();
    end
    In_Valid = 1'b0;
    check("bp_accepts", acc, 4);
    check("bp_in_ready", In_Ready, 0);
    check("bp_out_valid", Out_Valid, 1);
    check("bp_sum_held", Sum, first.sum);
    check("bp_unstable_cycles", bad, 0);
    Out_Ready = 1'b1;
    drain("bp_drain");
    check("bp_out_count", out_count - snap, 4);

    // Reset with 3 ops in flight: none of them may emerge.
    for (int i = 0; i < 3; i++) begin
      set_op(16'h1111 * (i + 1), 16'h0101, 1'b1, 1'b0);
      step();
    end
    In_Valid = 1'b0;
    Reset    = 1'b1;
    snap     = out_count;
    step();
    check("midrst_out_valid", Out_Valid, 0);
    check("midrst_sum", Sum, 0);
    check("midrst_cout", Cout, 0);
    check("midrst_in_ready", In_Ready, 1);
    Reset = 1'b0;
    repeat (10) step();
    check("midrst_no_output", out_count - snap, 0);

    // Pipe still works after the mid-stream reset.
    set_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    step();
    In_Valid = 1'b0;
    drain("post_rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
